// File: rtl/mips_pkg.sv
// mips_pkg: shared pcsrc encodings, instruction field positions and opcodes
package mips_pkg;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RSVD   = 2'b11;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
endpackage

// File: rtl/flopenr_n.sv
// flopenr_n: enable register with asynchronous active-low reset to RST_VAL
//   clk, rst_n : clock, async active-low reset
//   en, d      : load enable and data
//   q          : registered value
module flopenr_n #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= RST_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: multicycle MIPS PC/IR/MDR/ALUOut registers with next-PC and address muxes
//   control in : pcen, irwrite, iord, pcsrc (from controller); reset is async active-low
//   data in    : aluresult (ALU), memrdata (memory read data)
//   outputs    : memaddr, pc, instr and decoded fields, signimm, mdr, aluout, instr_count
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pcen,
  input  logic                 irwrite,
  input  logic                 iord,
  input  logic [1:0]           pcsrc,
  input  logic [WIDTH-1:0]     aluresult,
  input  logic [WIDTH-1:0]     memrdata,
  output logic [WIDTH-1:0]     memaddr,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     instr,
  output logic [5:0]           opcode,
  output logic [5:0]           funct,
  output logic [4:0]           rs,
  output logic [4:0]           rt,
  output logic [4:0]           rd,
  output logic [WIDTH-1:0]     signimm,
  output logic [WIDTH-1:0]     mdr,
  output logic [WIDTH-1:0]     aluout,
  output logic [CNT_WIDTH-1:0] instr_count
);
  logic [WIDTH-1:0] pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  // Jump target uses the already-incremented PC; reserved pcsrc holds the PC even with pcen
  always_comb
    pc_d = pcsrc == PCSRC_ALU    ? aluresult :
           pcsrc == PCSRC_ALUOUT ? aluout :
           pcsrc == PCSRC_JUMP   ? {pc[31:28], instr[25:0], 2'b00} : pc;
  assign cnt_d = irwrite ? cnt_q + 1'b1 : cnt_q;
  flopenr_n #(.W(WIDTH), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst_n(reset), .en(pcen), .d(pc_d), .q(pc));
  flopenr_n #(.W(WIDTH)) u_ir (
    .clk(clk), .rst_n(reset), .en(irwrite), .d(memrdata), .q(instr));
  flopenr_n #(.W(WIDTH)) u_mdr (
    .clk(clk), .rst_n(reset), .en(1'b1), .d(memrdata), .q(mdr));
  flopenr_n #(.W(WIDTH)) u_aluout (
    .clk(clk), .rst_n(reset), .en(1'b1), .d(aluresult), .q(aluout));
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign instr_count = cnt_q;
  assign memaddr = iord ? aluout : pc;
  assign opcode  = instr[OPCODE_MSB:OPCODE_LSB];
  assign funct   = instr[FUNCT_MSB:FUNCT_LSB];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign signimm = {{(WIDTH-16){instr[15]}}, instr[15:0]};
endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
Holds the multicycle MIPS architectural sequencing registers: PC, IR, data register (MDR) and ALUOut, plus the next-PC mux and memory-address mux. It sits directly downstream of the multicycle controller. It consumes pcen, irwrite, iord and pcsrc, and it produces opcode/funct back to the controller. It also supplies instruction fields to the register file, ALU and sign-extend logic.

Parameters:
WIDTH, 32, datapath width; must be 32 for MIPS field slicing
RESET_PC, 32'h0000_0000, value loaded into PC on reset
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset; reset==0 clears state immediately
pcen  input  1  PC write enable from controller (already includes branch/zero gating)
irwrite  input  1  IR write enable
iord  input  1  memory address select: 0=PC, 1=ALUOut
pcsrc  input  2  next-PC select
aluresult  input  WIDTH  combinational ALU result from datapath
memrdata  input  WIDTH  memory read data
memaddr  output  WIDTH  address to memory
pc  output  WIDTH  current PC
instr  output  WIDTH  IR contents
opcode  output  6  instr[31:26]
funct  output  6  instr[5:0]
rs  output  5  instr[25:21]
rt  output  5  instr[20:16]
rd  output  5  instr[15:11]
signimm  output  WIDTH  sign-extended instr[15:0]
mdr  output  WIDTH  data register
aluout  output  WIDTH  ALUOut register
instr_count  output  CNT_WIDTH  number of IR loads since reset

Behaviour:
- Reset (reset==0, asynchronous):
  - pc=RESET_PC; instr=0; mdr=0; aluout=0; instr_count=0.
  - Derived outputs follow from these values (opcode=0, funct=0, signimm=0).
  - Deassertion is taken at the next rising clk.
  - Reset asserted mid-instruction aborts the instruction; no partial update survives.
- Register updates (rising clk):
  - aluout <= aluresult, every cycle, unconditionally.
  - mdr <= memrdata, every cycle, unconditionally.
  - instr <= memrdata when irwrite=1; otherwise hold.
  - instr_count <= instr_count+1 when irwrite=1; wraps modulo 2^CNT_WIDTH with no saturation or flag.
  - pc <= pcnext when pcen=1; otherwise hold.
- pcnext (combinational):
  - pcsrc 00: aluresult (PC+4 during fetch, or branch target).
  - pcsrc 01: aluout (branch target computed in decode).
  - pcsrc 10: jump target {pc[31:28], instr[25:0], 2'b00}. It uses the already-incremented PC and the current IR.
  - pcsrc 11: reserved; pcnext=pc, so the PC holds even when pcen=1.
- memaddr = iord ? aluout : pc (combinational, no latency).
- Fetch cycle (pcen=1, irwrite=1, iord=0, pcsrc=00), all at the same edge:
  - memaddr presents the old pc.
  - IR captures the word at the old pc.
  - pc takes aluresult.
- Latency:
  - opcode/funct are valid one cycle after the irwrite edge and stay stable until the next irwrite.
  - mdr and aluout lag their inputs by exactly one cycle.
- pcen=1 with irwrite=0 (branch taken, jump): only pc changes; IR unchanged.
- X on pcsrc while pcen=0 has no effect on state.
- No handshakes with memory: memory is combinational-read in this design.

Decomposition:
- Shared package mips_pkg:
  - pcsrc encodings PCSRC_ALU=2'b00, PCSRC_ALUOUT=2'b01, PCSRC_JUMP=2'b10, PCSRC_RSVD=2'b11.
  - Field position constants (OPCODE_MSB/LSB, FUNCT_MSB/LSB).
  - Opcode constants shared with the controller (LW, SW, BEQ, ADDI, J, RTYPE).
- One natural sub-module: flopenr_n, a parameterized enable register with asynchronous active-low reset and a reset-value parameter.
  - Instantiated for PC and IR.
  - Instantiated with enable tied high for MDR and ALUOut.

Test Plan:
- Reset: drive reset=0 mid-cycle with pcen=1 -> pc=0, instr=0, instr_count=0 immediately; after release, the first fetch with memrdata=32'h8C08_0004 and aluresult=4 -> instr=32'h8C08_0004, opcode=6'b100011, pc=4, instr_count=1.
- Load address path: iord=1 with aluresult=32'h0000_0010 one cycle earlier -> memaddr=32'h10; memrdata=32'hDEAD_BEEF -> mdr=32'hDEAD_BEEF one cycle later; pc and instr unchanged.
- Branch taken: pc=32'h0000_0020, pcsrc=01, aluout=32'h0000_0040, pcen=1, irwrite=0 -> pc=32'h40, instr held; repeat with pcen=0 -> pc holds 32'h20.
- Jump: pc=32'h1000_0008, instr=32'h0800_0100 (j), pcsrc=10, pcen=1 -> pc=32'h1000_0400; signimm=32'h0000_0100.
- Reserved/edge: pcsrc=11 with pcen=1 -> pc unchanged; instr imm 16'h8000 -> signimm=32'hFFFF_8000; with CNT_WIDTH=4, 17 irwrite pulses -> instr_count=1 (wrap).
- R-type decode: IR load of 32'h0109_502A -> opcode=0, funct=6'b101010, rs=8, rt=9, rd=10, stable until the next irwrite.
